// File: rtl/fd_checker.sv
// fd_checker: consumes an AXI-Stream of replicated 16-bit counter words,
// compares every lane of every accepted beat against a local incrementing
// reference, and reports beat/error counts plus a snapshot of the first bad beat.

// Per-lane comparator: flags a lane whose word differs from the reference.
module fd_lane_cmp (
  input  logic [15:0] word,
  input  logic [15:0] expected,
  output logic        mis
);
  assign mis = (word != expected);
endmodule

module fd_checker #(
  parameter int DW = 512            // multiple of 16; at most 64 lanes fit first_err_lane
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          throttle,
  input  logic [31:0]   frame_beats,
  input  logic [DW-1:0] axis_tdata,
  input  logic          axis_tvalid,
  output logic          axis_tready,
  output logic          done,
  output logic          error,
  output logic [31:0]   beats_rcvd,
  output logic [31:0]   err_count,
  output logic [31:0]   first_err_beat,
  output logic [5:0]    first_err_lane,
  output logic [15:0]   first_err_expected,
  output logic [15:0]   first_err_actual
);
  localparam int LANES = DW / 16;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 state;
  logic [2:0]             cyc_cnt;
  logic [2:0]             cyc_nxt;
  logic [31:0]            frame_lat;
  logic [15:0]            expected;
  logic [LANES-1:0][15:0] lane_w;
  logic [LANES-1:0]       lane_mis;
  logic                   mis_any;
  logic [5:0]             bad_lane;
  logic [15:0]            bad_word;
  logic                   gate;
  logic                   accept;
  logic                   last_beat;

  assign lane_w = axis_tdata;

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      fd_lane_cmp u_cmp (
        .word     (lane_w[g]),
        .expected (expected),
        .mis      (lane_mis[g])
      );
    end
  endgenerate

  assign mis_any = |lane_mis;

  // Lowest mismatching lane and its word; scanning downward lets lane 0 win.
  always_comb begin
    bad_lane = '0;
    bad_word = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_mis[i]) begin
        bad_lane = 6'(i);
        bad_word = lane_w[i];
      end
    end
  end

  // tready is registered, so gate on the counter value it will be seen with.
  assign cyc_nxt   = cyc_cnt + 3'd1;
  assign gate      = !throttle || (cyc_nxt >= 3'd2);
  assign accept    = (state == S_RUN) && axis_tvalid && axis_tready;
  assign last_beat = (beats_rcvd + 32'd1) == frame_lat;

  // Free-running throttle phase counter.
  always_ff @(posedge clk) begin
    if (!resetn) cyc_cnt <= '0;
    else         cyc_cnt <= cyc_nxt;
  end

  // Run control FSM with all status outputs registered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state              <= S_IDLE;
      axis_tready        <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      frame_lat          <= '0;
      expected           <= '0;
      beats_rcvd         <= '0;
      err_count          <= '0;
      first_err_beat     <= '0;
      first_err_lane     <= '0;
      first_err_expected <= '0;
      first_err_actual   <= '0;
    end else if (start) begin
      // start (re)arms from any state; a beat in this cycle is dropped
      frame_lat          <= frame_beats;
      expected           <= '0;
      beats_rcvd         <= '0;
      err_count          <= '0;
      error              <= 1'b0;
      first_err_beat     <= '0;
      first_err_lane     <= '0;
      first_err_expected <= '0;
      first_err_actual   <= '0;
      if (frame_beats == 32'd0) begin
        state       <= S_DONE;
        done        <= 1'b1;
        axis_tready <= 1'b0;
      end else begin
        state       <= S_RUN;
        done        <= 1'b0;
        axis_tready <= gate;
      end
    end else begin
      case (state)
        S_IDLE: axis_tready <= 1'b0;
        S_RUN: begin
          axis_tready <= gate;
          if (accept) begin
            beats_rcvd <= beats_rcvd + 32'd1;
            expected   <= expected + 16'd1;
            if (mis_any) begin
              error <= 1'b1;
              if (err_count != '1) err_count <= err_count + 32'd1;
              if (!error) begin
                first_err_beat     <= beats_rcvd;
                first_err_lane     <= bad_lane;
                first_err_expected <= expected;
                first_err_actual   <= bad_word;
              end
            end
            if (last_beat) begin
              state       <= S_DONE;
              done        <= 1'b1;
              axis_tready <= 1'b0;
            end
          end
        end
        S_DONE: axis_tready <= 1'b0;
        default: begin
          state       <= S_IDLE;
          axis_tready <= 1'b0;
        end
      endcase
    end
  end
endmodule
